result_writeback: RTL and testbench



---
 rtl/result_writeback_pkg.sv | 30 +++
 rtl/result_writeback_if.sv | 30 +++
 rtl/result_writeback.sv | 132 +++++++++++++
 tb/tb_result_writeback.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_writeback_pkg.sv
// Shared definitions for the result writeback stage: FSM encoding,
// opCode field positions and ZNC flag bit indices.
package result_writeback_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } wb_state_t;

    // opCode field layout
    localparam int CLASS_HI = 15;
    localparam int CLASS_LO = 14;
    localparam int FUPD_BIT = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 8;

    localparam logic [1:0] CLASS_DUAL = 2'b10;

    // ZNC flag ordering {Z,N,C}
    localparam int Z_IDX = 2;
    localparam int N_IDX = 1;
    localparam int C_IDX = 0;

    // True when the instruction class produces both an A and a B result
    function automatic logic is_dual(input logic [15:0] op);
        return (op[CLASS_HI:CLASS_LO] == CLASS_DUAL);
    endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Decoder-to-writeback handshake plus register-file write port and flags.
interface result_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       opCode;
    logic [DATA_W-1:0] A_in;
    logic [DATA_W-1:0] B_in;
    logic [2:0]        ZNC_in;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        flags;
    logic              busy;

    // Upstream decoder / register-file observer side
    modport master (
        output flush, in_valid, opCode, A_in, B_in, ZNC_in,
        input  in_ready, rf_we, rf_waddr, rf_wdata, flags, busy
    );

    // Writeback stage side
    modport slave (
        input  flush, in_valid, opCode, A_in, B_in, ZNC_in,
        output in_ready, rf_we, rf_waddr, rf_wdata, flags, busy
    );
endinterface

// File: rtl/result_writeback.sv
// Writeback stage: holds one op, writes A (and B for dual-result ops) to
// the register file through a single port, and owns the ZNC flag register.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    result_writeback_if.slave  bus
);

    wb_state_t         r_state;
    wb_state_t         w_state_next;

    logic [ADDR_W-1:0] r_rd;
    logic              r_dual;
    logic              r_fupd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_znc;
    logic [2:0]        r_flags;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_commit;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // opCode bits that carry no meaning for writeback
    logic              w_unused_opcode_bits;
    assign w_unused_opcode_bits = ^{bus.opCode[13], bus.opCode[7:0]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write-port outputs, handshake and next state; flush only redirects
    // the next state and blocks acceptance, the current write still happens
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_commit     = 1'b0;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_wdata      = '0;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
            end
            WR_A: begin
                w_we    = 1'b1;
                w_waddr = r_rd;
                w_wdata = r_a;
                if (!r_dual) begin
                    w_in_ready = 1'b1;
                    w_commit   = 1'b1;
                end
            end
            WR_B: begin
                w_we       = 1'b1;
                w_waddr    = r_rd + ADDR_W'(1);  // rd = max wraps to 0
                w_wdata    = r_b;
                w_in_ready = 1'b1;
                w_commit   = 1'b1;
            end
            default: ;
        endcase

        if (bus.flush) begin
            w_in_ready = 1'b0;
        end
        w_accept = bus.in_valid && w_in_ready;

        if (bus.flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = w_accept ? WR_A : IDLE;
                WR_A:    w_state_next = r_dual ? WR_B : (w_accept ? WR_A : IDLE);
                WR_B:    w_state_next = w_accept ? WR_A : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Hold registers load on accept; a commit in the same cycle already
    // consumed the old contents through the combinational write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd   <= '0;
            r_dual <= 1'b0;
            r_fupd <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_znc  <= '0;
        end else if (w_accept) begin
            r_rd   <= ADDR_W'(bus.opCode[RD_HI:RD_LO]);
            r_dual <= is_dual(bus.opCode);
            r_fupd <= bus.opCode[FUPD_BIT];
            r_a    <= bus.A_in;
            r_b    <= bus.B_in;
            r_znc  <= {bus.ZNC_in[Z_IDX], bus.ZNC_in[N_IDX], bus.ZNC_in[C_IDX]};
        end
    end

    // Architectural flags update at the end of an unflushed commit cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 3'b000;
        end else if (w_commit && !bus.flush && r_fupd) begin
            r_flags <= r_znc;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.rf_we    = w_we;
    assign bus.rf_waddr = w_waddr;
    assign bus.rf_wdata = w_wdata;
    assign bus.flags    = r_flags;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_result_writeback;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    result_writeback_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    result_writeback #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queue of register-file writes still owed, each tagged with
    // whether it completes its op and the flag update that comes with it.
    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        bit          last;
        bit          fupd;
        logic [2:0]  znc;
    } wr_t;

    wr_t        pend[$];
    logic [2:0] m_flags;

    typedef struct {
        logic [15:0] op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  znc;
        logic [3:0]  exp_addr_a;
        bit          exp_dual;
        logic [3:0]  exp_addr_b;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] z, input bit fl);
        bus.in_valid = v;
        bus.opCode   = op;
        bus.A_in     = a;
        bus.B_in     = b;
        bus.ZNC_in   = z;
        bus.flush    = fl;
    endtask

    // One clock of model-checked operation; inputs applied just after a posedge
    task automatic cycle(input bit v, input logic [15:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] z, input bit fl,
                         output bit acc);
        bit  exp_rdy;
        bit  dual;
        wr_t w;
        drive(v, op, a, b, z, fl);
        @(negedge clk);
        exp_rdy = !fl && (pend.size() <= 1);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("rf_we", bus.rf_we, pend.size() != 0);
        if (pend.size() != 0) begin
            chk("rf_waddr", bus.rf_waddr, pend[0].addr);
            chk("rf_wdata", bus.rf_wdata, pend[0].data);
        end
        chk("flags", bus.flags, m_flags);
        chk("busy", bus.busy, pend.size() != 0);
        acc = v && exp_rdy;
        @(posedge clk);
        if (pend.size() != 0) begin
            w = pend.pop_front();
            if (w.last && w.fupd && !fl) m_flags = w.znc;
        end
        if (fl) pend.delete();
        if (acc) begin
            dual = (op[15:14] == 2'b10);
            pend.push_back('{addr: op[11:8], data: a, last: !dual, fupd: op[12], znc: z});
            if (dual)
                pend.push_back('{addr: 4'(op[11:8] + 4'd1), data: b, last: 1'b1, fupd: op[12], znc: z});
        end
        #1;
    endtask

    initial begin
        bit          acc;
        bit          v;
        bit          fl;
        logic [15:0] op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  z;

        n_chk   = 0;
        n_fail  = 0;
        m_flags = 3'b000;
        reset   = 1'b1;
        drive(0, 16'h0, 16'h0, 16'h0, 3'b0, 0);

        //           op        A        B        ZNC     addrA  dual addrB flags
        vecs[0] = '{16'h1500, 16'hBEEF, 16'h0000, 3'b010, 4'd5,  0, 4'd0,  3'b010};
        vecs[1] = '{16'h9F00, 16'h1234, 16'h5678, 3'b001, 4'd15, 1, 4'd0,  3'b001};
        vecs[2] = '{16'h1200, 16'h0A0A, 16'h0000, 3'b100, 4'd2,  0, 4'd0,  3'b100};
        vecs[3] = '{16'h0300, 16'h7777, 16'h0000, 3'b111, 4'd3,  0, 4'd0,  3'b100};
        vecs[4] = '{16'h8A00, 16'h1111, 16'h2222, 3'b111, 4'd10, 1, 4'd11, 3'b100};
        vecs[5] = '{16'h5C00, 16'hCAFE, 16'h0000, 3'b011, 4'd12, 0, 4'd0,  3'b011};
        vecs[6] = '{16'hC000, 16'hFFFF, 16'h0000, 3'b101, 4'd0,  0, 4'd0,  3'b011};

        // Reset state
        #12;
        chk("reset rf_we", bus.rf_we, 1'b0);
        chk("reset rf_waddr", bus.rf_waddr, 4'd0);
        chk("reset rf_wdata", bus.rf_wdata, 16'd0);
        chk("reset flags", bus.flags, 3'b000);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed table: each op issued alone from IDLE
        for (int i = 0; i < 7; i++) begin
            drive(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].znc, 0);
            @(negedge clk);
            chk($sformatf("vec%0d accept ready", i), bus.in_ready, 1'b1);
            @(posedge clk);
            #1 drive(0, 16'h0, 16'h0, 16'h0, 3'b0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d A we", i), bus.rf_we, 1'b1);
            chk($sformatf("vec%0d A addr", i), bus.rf_waddr, vecs[i].exp_addr_a);
            chk($sformatf("vec%0d A data", i), bus.rf_wdata, vecs[i].a);
            chk($sformatf("vec%0d A ready", i), bus.in_ready, !vecs[i].exp_dual);
            @(posedge clk);
            #1;
            if (vecs[i].exp_dual) begin
                @(negedge clk);
                chk($sformatf("vec%0d B we", i), bus.rf_we, 1'b1);
                chk($sformatf("vec%0d B addr", i), bus.rf_waddr, vecs[i].exp_addr_b);
                chk($sformatf("vec%0d B data", i), bus.rf_wdata, vecs[i].b);
                chk($sformatf("vec%0d B ready", i), bus.in_ready, 1'b1);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            chk($sformatf("vec%0d idle we", i), bus.rf_we, 1'b0);
            chk($sformatf("vec%0d flags", i), bus.flags, vecs[i].exp_flags);
            chk($sformatf("vec%0d idle busy", i), bus.busy, 1'b0);
            @(posedge clk);
            #1;
        end
        m_flags = vecs[6].exp_flags;

        // Reset asserted in the middle of WR_B of a dual op at rd = 3
        drive(1, 16'h9300, 16'h0001, 16'h0002, 3'b111, 0);
        @(posedge clk);
        #1 drive(0, 16'h0, 16'h0, 16'h0, 3'b0, 0);
        @(posedge clk);
        #1;
        chk("wrb pre-reset we", bus.rf_we, 1'b1);
        chk("wrb pre-reset addr", bus.rf_waddr, 4'd4);
        reset = 1'b1;
        #1;
        chk("async reset we", bus.rf_we, 1'b0);
        chk("async reset busy", bus.busy, 1'b0);
        chk("async reset flags", bus.flags, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        pend.delete();
        m_flags = 3'b000;
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 16'h0, 16'h0, 3'b0, 0, acc);

        // Back-to-back single ops with in_valid held high
        cycle(1, 16'h1100, 16'hA001, 16'h0, 3'b100, 0, acc);
        cycle(1, 16'h0200, 16'hA002, 16'h0, 3'b010, 0, acc);
        cycle(1, 16'h1300, 16'hA003, 16'h0, 3'b001, 0, acc);
        cycle(1, 16'h4400, 16'hA004, 16'h0, 3'b110, 0, acc);
        for (int i = 0; i < 2; i++) cycle(0, 16'h0, 16'h0, 16'h0, 3'b0, 0, acc);

        // Back-to-back dual ops: one op every two cycles
        cycle(1, 16'h9500, 16'hB001, 16'hB002, 3'b011, 0, acc);
        cycle(1, 16'h9600, 16'hB003, 16'hB004, 3'b101, 0, acc);
        cycle(1, 16'h9600, 16'hB003, 16'hB004, 3'b101, 0, acc);
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 16'h0, 16'h0, 3'b0, 0, acc);

        // Flush in WR_A of a dual op, with a new op offered in the flush cycle
        cycle(1, 16'h9700, 16'hC001, 16'hC002, 3'b111, 0, acc);
        cycle(1, 16'h1800, 16'hC003, 16'h0, 3'b000, 1, acc);
        chk("flush blocks accept", acc, 1'b0);
        for (int i = 0; i < 2; i++) cycle(0, 16'h0, 16'h0, 16'h0, 3'b0, 0, acc);

        // Randomized traffic; unaccepted offers are held stable
        v  = 0;
        op = 0;
        a  = 0;
        b  = 0;
        z  = 0;
        for (int i = 0; i < 400; i++) begin
            if (!v || acc) begin
                v  = ($urandom_range(0, 3) != 0);
                op = 16'($urandom);
                if ($urandom_range(0, 1) == 1) op[15:14] = 2'b10;
                a  = 16'($urandom);
                b  = 16'($urandom);
                z  = 3'($urandom);
            end
            fl = ($urandom_range(0, 15) == 0);
            cycle(v, op, a, b, z, fl, acc);
        end
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 16'h0, 16'h0, 3'b0, 0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
